// File: rtl/instr_encoder.sv
// RV32I field-bundle to instruction-word encoder with a small output FIFO.
// Bundles whose immediate cannot be represented in the selected format are dropped and counted.
module instr_encoder #(
  parameter int INSTR_SIZE = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [31:0]           imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INSTR_SIZE-1:0] out_instr,
  output logic                  err,
  input  logic                  err_clr,
  output logic [15:0]           instr_cnt,
  output logic [7:0]            err_cnt
);

  localparam logic [6:0] OPCODE_ALU     = 7'b0110011;
  localparam logic [6:0] OPCODE_ALU_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD    = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE   = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPCODE_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPCODE_JUMP    = 7'b1101111;

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  // True when v lies in the two's-complement range of a bits-wide field.
  function automatic logic fits(input logic signed [31:0] v, input int bits);
    return (v >= -(2 ** (bits - 1))) && (v <= (2 ** (bits - 1)) - 1);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic signed [31:0]   imm_s;
  logic [31:0]          enc;
  logic                 bad;
  logic                 started;
  logic [CNT_W-1:0]     count;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [INSTR_SIZE-1:0] mem [FIFO_DEPTH];
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic                 err_set;

  assign imm_s = imm;

  always_comb begin
    enc = '0;
    bad = 1'b0;
    case (opcode)
      OPCODE_ALU: enc = {funct7, rs2, rs1, funct3, rd, opcode};
      OPCODE_ALU_IMM, OPCODE_LOAD: begin
        enc = {imm[11:0], rs1, funct3, rd, opcode};
        bad = !fits(imm_s, 12);
      end
      OPCODE_STORE: begin
        enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        bad = !fits(imm_s, 12);
      end
      OPCODE_BRANCH: begin
        enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        bad = !fits(imm_s, 13) || imm[0];
      end
      OPCODE_AUIPC: begin
        enc = {imm[31:12], rd, opcode};
        bad = (imm[11:0] != 12'd0);
      end
      OPCODE_JUMP: begin
        enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        bad = !fits(imm_s, 21) || imm[0];
      end
      default: bad = 1'b1;
    endcase
  end

  // in_ready depends only on registered occupancy, never on out_ready.
  assign in_ready  = started && (count < CNT_W'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign out_instr = out_valid ? mem[rd_ptr] : '0;

  assign accept  = in_valid && in_ready;
  assign push    = accept && !bad;
  assign err_set = accept && bad;
  assign pop     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started   <= 1'b0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      err       <= 1'b0;
      err_cnt   <= '0;
      instr_cnt <= '0;
    end else begin
      started <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A new error on the same edge as err_clr leaves the flag set.
      err <= err_set || (err && !err_clr);
      if (err_set) err_cnt <= sat_inc(err_cnt);
      if (pop) instr_cnt <= instr_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= INSTR_SIZE'(enc);
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed vector table, FIFO/error corner sequences and a random round-trip decode check.
module tb_instr_encoder;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_II = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_U  = 7'b0010111;
  localparam logic [6:0] OP_J  = 7'b1101111;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        bad;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [4:0]  rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [31:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        err;
  logic        err_clr = 1'b0;
  logic [15:0] instr_cnt;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  instr_encoder #(.INSTR_SIZE(32), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .err(err), .err_clr(err_clr), .instr_cnt(instr_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic set_vec(input vec_t v);
    opcode = v.op; funct3 = v.f3; funct7 = v.f7;
    rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_instr_cnt", 32'(instr_cnt), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_release_in_ready", 32'(in_ready), 32'd1);
  endtask

  // Independent RV32I immediate decoder.
  function automatic logic [31:0] dec_imm(input logic [31:0] w);
    case (w[6:0])
      OP_II, OP_LD: return {{20{w[31]}}, w[31:20]};
      OP_S:         return {{20{w[31]}}, w[31:25], w[11:7]};
      OP_B:         return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      OP_U:         return {w[31:12], 12'd0};
      OP_J:         return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default:      return 32'd0;
    endcase
  endfunction

  function automatic bit rt_ok(input vec_t e, input logic [31:0] w);
    bit ok, is_r, is_i, is_s, is_b, is_u, is_j;
    is_r = (e.op == OP_R);
    is_i = (e.op == OP_II) || (e.op == OP_LD);
    is_s = (e.op == OP_S);
    is_b = (e.op == OP_B);
    is_u = (e.op == OP_U);
    is_j = (e.op == OP_J);
    ok = (w[6:0] == e.op);
    if (is_r || is_i || is_u || is_j) ok = ok && (w[11:7] == e.rd);
    if (is_r || is_i || is_s || is_b) ok = ok && (w[19:15] == e.rs1) && (w[14:12] == e.f3);
    if (is_r || is_s || is_b) ok = ok && (w[24:20] == e.rs2);
    if (is_r) ok = ok && (w[31:25] == e.f7);
    else ok = ok && (dec_imm(w) == e.imm);
    return ok;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    logic [6:0] ops [7];
    logic [31:0] r;
    ops = '{OP_R, OP_II, OP_LD, OP_S, OP_B, OP_U, OP_J};
    r = $urandom;
    v.op  = ops[$urandom_range(6)];
    v.f3  = 3'($urandom);
    v.f7  = 7'($urandom);
    v.rd  = 5'($urandom);
    v.rs1 = 5'($urandom);
    v.rs2 = 5'($urandom);
    case (v.op)
      OP_II, OP_LD, OP_S: v.imm = {{20{r[11]}}, r[11:0]};
      OP_B:               v.imm = {{19{r[12]}}, r[12:1], 1'b0};
      OP_U:               v.imm = {r[31:12], 12'd0};
      OP_J:               v.imm = {{11{r[20]}}, r[20:1], 1'b0};
      default:            v.imm = r;
    endcase
    v.bad = 1'b0;
    v.exp = '0;
    return v;
  endfunction

  vec_t tbl [14];
  vec_t va, vb, vc, vbad;
  vec_t q [$];
  vec_t h;
  int exp_err_cnt;
  int base_cnt, low_rdy, acc, cyc;
  logic [7:0] ec0;

  initial begin
    tbl[0]  = '{OP_R,  3'd0, 7'h00, 5'd3,  5'd1, 5'd2, 32'd0,         1'b0, 32'h002081B3};
    tbl[1]  = '{OP_B,  3'd0, 7'h00, 5'd0,  5'd1, 5'd2, 32'hFFFFFFFC,  1'b0, 32'hFE208EE3};
    tbl[2]  = '{OP_B,  3'd0, 7'h00, 5'd0,  5'd1, 5'd2, 32'd3,         1'b1, 32'd0};
    tbl[3]  = '{OP_J,  3'd0, 7'h00, 5'd1,  5'd0, 5'd0, 32'd2048,      1'b0, 32'h001000EF};
    tbl[4]  = '{OP_LD, 3'd2, 7'h00, 5'd5,  5'd2, 5'd0, 32'hFFFFFFFF,  1'b0, 32'hFFF12283};
    tbl[5]  = '{OP_U,  3'd0, 7'h00, 5'd1,  5'd0, 5'd0, 32'h00001001,  1'b1, 32'd0};
    tbl[6]  = '{OP_S,  3'd2, 7'h00, 5'd0,  5'd2, 5'd5, 32'd8,         1'b0, 32'h00512423};
    tbl[7]  = '{OP_II, 3'd0, 7'h00, 5'd1,  5'd0, 5'd0, 32'd2047,      1'b0, 32'h7FF00093};
    tbl[8]  = '{OP_II, 3'd0, 7'h00, 5'd1,  5'd0, 5'd0, 32'd2048,      1'b1, 32'd0};
    tbl[9]  = '{7'b0110111, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h1000,  1'b1, 32'd0};
    tbl[10] = '{OP_U,  3'd0, 7'h00, 5'd10, 5'd0, 5'd0, 32'h12345000,  1'b0, 32'h12345517};
    tbl[11] = '{OP_J,  3'd0, 7'h00, 5'd1,  5'd0, 5'd0, 32'd1,         1'b1, 32'd0};
    tbl[12] = '{OP_R,  3'd0, 7'h20, 5'd3,  5'd1, 5'd2, 32'd0,         1'b0, 32'h402081B3};
    tbl[13] = '{OP_S,  3'd2, 7'h00, 5'd0,  5'd2, 5'd5, 32'hFFFFF7FF,  1'b1, 32'd0};

    do_reset();

    exp_err_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      set_vec(tbl[i]);
      in_valid = 1'b1; out_ready = 1'b1; err_clr = 1'b0;
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      if (tbl[i].bad) begin
        exp_err_cnt++;
        chk($sformatf("vec%0d_err", i), 32'(err), 32'd1);
        chk($sformatf("vec%0d_no_out", i), 32'(out_valid), 32'd0);
        chk($sformatf("vec%0d_err_cnt", i), 32'(err_cnt), 32'(exp_err_cnt));
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk($sformatf("vec%0d_err_clr", i), 32'(err), 32'd0);
      end else begin
        chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'd1);
        chk($sformatf("vec%0d_out_instr", i), out_instr, tbl[i].exp);
        step();
        chk($sformatf("vec%0d_drained", i), 32'(out_valid), 32'd0);
      end
    end
    chk("table_instr_cnt", 32'(instr_cnt), 32'd8);

    // err_clr on the same edge as a fresh error: set wins, counter still advances.
    vbad = tbl[2];
    set_vec(vbad);
    in_valid = 1'b1;
    step();
    chk("setclr_err_pre", 32'(err), 32'd1);
    ec0 = err_cnt;
    err_clr = 1'b1;
    step();
    chk("setclr_err", 32'(err), 32'd1);
    chk("setclr_err_cnt", 32'(err_cnt), 32'(ec0) + 32'd1);
    in_valid = 1'b0;
    step();
    err_clr = 1'b0;
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_keeps_cnt", 32'(err_cnt), 32'(ec0) + 32'd1);

    // Back-pressure: two entries fill the FIFO, third waits, order preserved.
    do_reset();
    va = tbl[0]; vb = tbl[12]; vc = tbl[7];
    out_ready = 1'b0;
    set_vec(va); in_valid = 1'b1;
    step();
    set_vec(vb);
    chk("fill_in_ready1", 32'(in_ready), 32'd1);
    step();
    chk("full_in_ready", 32'(in_ready), 32'd0);
    set_vec(vc);
    step();
    chk("hold_out_instr", out_instr, va.exp);
    chk("hold_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    chk("drain_a", out_instr, va.exp);
    step();
    chk("drain_b", out_instr, vb.exp);
    chk("drain_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("drain_c", out_instr, vc.exp);
    step();
    chk("drain_empty", 32'(out_valid), 32'd0);
    chk("drain_instr_cnt", 32'(instr_cnt), 32'd3);

    // Sustained valid/ready gives one instruction per cycle.
    base_cnt = int'(instr_cnt);
    low_rdy = 0;
    set_vec(tbl[0]);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!in_ready) low_rdy++;
      step();
    end
    in_valid = 1'b0;
    chk("stream_ready_drops", 32'(low_rdy), 32'd0);
    chk("stream_throughput", 32'(int'(instr_cnt) - base_cnt), 32'd19);
    step();

    // err_cnt saturates.
    set_vec(tbl[8]);
    in_valid = 1'b1;
    repeat (300) step();
    in_valid = 1'b0;
    chk("err_cnt_sat", 32'(err_cnt), 32'd255);

    // Reset mid-stream drops buffered entries immediately.
    set_vec(tbl[0]);
    in_valid = 1'b1; out_ready = 1'b0;
    step(); step();
    in_valid = 1'b0;
    chk("mid_pre_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_out_instr", out_instr, 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd0);
    chk("mid_err_cnt", 32'(err_cnt), 32'd0);
    chk("mid_instr_cnt", 32'(instr_cnt), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("mid_release_ready", 32'(in_ready), 32'd1);
    chk("mid_no_transfer", 32'(instr_cnt), 32'd0);
    chk("mid_release_empty", 32'(out_valid), 32'd0);

    // Random legal bundles, random back-pressure, decoded against inputs.
    acc = 0; cyc = 0;
    while (acc < 10000 && cyc < 60000) begin
      set_vec(rand_vec());
      h.op = opcode; h.f3 = funct3; h.f7 = funct7; h.rd = rd;
      h.rs1 = rs1; h.rs2 = rs2; h.imm = imm; h.bad = 1'b0; h.exp = '0;
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(4) > 1);
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rt_extra actual=%h expected=none", out_instr);
        end else begin
          if (!rt_ok(q[0], out_instr)) begin
            errors++;
            $display("FAIL rt_decode actual=%h expected op=%b rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%h imm=%h",
                     out_instr, q[0].op, q[0].rd, q[0].rs1, q[0].rs2, q[0].f3, q[0].f7, q[0].imm);
          end
          void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(h);
        acc++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      if (out_valid) begin
        checks++;
        if (!rt_ok(q[0], out_instr)) begin
          errors++;
          $display("FAIL rt_drain actual=%h expected op=%b imm=%h", out_instr, q[0].op, q[0].imm);
        end
        void'(q.pop_front());
      end
      step();
    end
    chk("rt_accepted", 32'(acc), 32'd10000);
    chk("rt_leftover", 32'(q.size()), 32'd0);
    chk("rt_instr_cnt", 32'(instr_cnt), 32'd10000);
    chk("rt_no_err", 32'(err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter INSTR_SIZE, default `WORD_SIZE (32), width of the encoded instruction word.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, number of output buffer entries (power of two, >=2).
REQ-003 SHALL have clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have in_valid  input  1  field bundle valid.
REQ-006 SHALL have in_ready  output  1  encoder can accept a bundle this cycle.
REQ-007 SHALL have opcode  input  7, funct3  input  3, funct7  input  7  RV32I opcode and function fields.
REQ-008 SHALL have rd, rs1, rs2  input  `ARCH_REG_INDEX_SIZE (5) each  architectural register indices.
REQ-009 SHALL have imm  input  `WORD_SIZE  sign-extended immediate, in the same form the decoder produces.
REQ-010 SHALL have out_valid  output  1, out_ready  input  1, out_instr  output  INSTR_SIZE  encoded instruction stream.
REQ-011 SHALL have err  output  1  sticky encode-error flag; err_clr  input  1  clears it.
REQ-012 SHALL have instr_cnt  output  16  instructions delivered; err_cnt  output  8  bundles rejected.

Function
REQ-013 SHALL accept a bundle on an edge where in_valid && in_ready; SHALL transfer out on an edge where out_valid && out_ready.
REQ-014 SHALL drive in_ready = (entries < FIFO_DEPTH), with no combinational path from out_ready.
REQ-015 SHALL select format by opcode: `OPCODE_ALU->R; `OPCODE_ALU_IMM, `OPCODE_LOAD->I; `OPCODE_STORE->S; `OPCODE_BRANCH->B; `OPCODE_AUIPC->U; `OPCODE_JUMP->J; any other opcode is an error.
REQ-016 R: {funct7, rs2, rs1, funct3, rd, opcode}.
REQ-017 I: {imm[11:0], rs1, funct3, rd, opcode}.
REQ-018 S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-019 B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-020 U: {imm[31:12], rd, opcode}.
REQ-021 J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-022 SHALL flag an error when imm is not representable: I/S: imm[31:11] not all equal; B: imm[31:12] not all equal or imm[0]=1; J: imm[31:20] not all equal or imm[0]=1; U: imm[11:0] != 0.
REQ-023 An erroneous accepted bundle SHALL NOT enter the FIFO; SHALL set err and increment err_cnt (saturating at 255) on the accept edge.
REQ-024 A valid accepted bundle SHALL be pushed; out_valid SHALL rise the cycle after accept when the FIFO was empty (latency 1).
REQ-025 out_instr SHALL be the head entry and SHALL hold stable while out_valid && !out_ready.
REQ-026 Simultaneous push and pop SHALL leave occupancy unchanged and preserve order; pop SHALL never occur when empty.
REQ-027 Sustained in_valid and out_ready SHALL yield one instruction per cycle after initial latency.
REQ-028 instr_cnt SHALL increment on each output transfer, wrapping 0xFFFF->0x0000.
REQ-029 err_clr SHALL clear err on the next edge; if an error occurs on the same edge, err SHALL be 1 (set wins); err_clr SHALL NOT affect err_cnt.
REQ-030 Round-trip: decoding out_instr SHALL reproduce opcode, rd, rs1, rs2, funct3, funct7 and imm for every field used by the format.

Reset
REQ-031 While rst_n=0: FIFO empty, out_valid=0, in_ready=0, err=0, instr_cnt=0, err_cnt=0, out_instr=0.
REQ-032 in_ready SHALL be 1 from the first edge after rst_n deasserts.
REQ-033 Reset asserted mid-stream SHALL discard all buffered instructions immediately, without completing a pending transfer.

Verification
REQ-034 ADD x3,x1,x2 (opcode 0110011, f3 0, f7 0) -> out_instr 0x002081B3 one cycle after accept.
REQ-035 BEQ x1,x2,imm=-4 -> 0xFE208EE3; BEQ with imm=3 -> dropped, err=1, err_cnt=1, no out_valid.
REQ-036 out_ready=0, push three valid bundles -> third waits (in_ready=0 after two), then order preserved on drain, instr_cnt=3.
REQ-037 JAL x1,imm=2048 -> 0x001000EF; LW x5,-1(x2) -> 0xFFF12283; AUIPC imm=0x1001 -> error.
REQ-038 err_clr together with a new error on one edge -> err stays 1, err_cnt increments.
REQ-039 Random round-trip: 10k random legal bundles at random out_ready -> decoder fields match inputs, no loss or reordering.
